cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Responder at the memory end of the cache-line interface that the I/D arbiter drives: it accepts one whole-line read or write request (`pmem_*` side of the arbiter) and carries it out as a fixed-length burst of 64-bit beats on the physical-memory port. It also collects read beats into a full line and presents the line with a single-cycle response. The block sits between the arbiter (or L2) and the physical memory model.

## Interface
- `s_offset`, default 5: line offset bits; request addresses are line-aligned to `2**s_offset` bytes.
- `s_line`, default 256: line width in bits.
- `s_burst`, default 64: beat width in bits; `BEATS = s_line/s_burst` (4 by default).
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  reset; synchronous and active-high.
- `line_addr`  in  32  byte address of the requested line.
- `line_read`  in  1  line read request, level-held until `line_resp`.
- `line_write`  in  1  line write request, level-held until `line_resp`.
- `line_wdata`  in  s_line  line to write.
- `line_rdata`  out  s_line  assembled read line.
- `line_resp`  out  1  one-cycle completion pulse.
- `burst_addr`  out  32  line-aligned burst address.
- `burst_read`  out  1  burst read request.
- `burst_write`  out  1  burst write request.
- `burst_wdata`  out  s_burst  current write beat.
- `burst_rdata`  in  s_burst  current read beat.
- `burst_resp`  in  1  qualifies one beat (read data valid / write beat accepted).

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `line_write` takes priority over `line_read` if both are high.
  - On a request, latch `line_addr` with the low `s_offset` bits zeroed, latch `line_wdata` (write only), clear the beat counter, and go to WRITE or READ.
- READ:
  - `burst_read` = 1.
  - On each `burst_resp`, store `burst_rdata` into beat slot `count`, where slot k occupies bits `[k*s_burst +: s_burst]` (beat 0 is the LSBs).
  - Then increment `count`. A `burst_resp` when `count == BEATS-1` moves the FSM to DONE.
- WRITE:
  - `burst_write` = 1 and `burst_wdata` = latched line slot `count`.
  - On each `burst_resp`, increment `count`. The last beat moves the FSM to DONE.
- DONE: `line_resp` = 1 for exactly one cycle, then go to IDLE.
- `line_rdata` holds the last completed read line until the next read completes. It is not modified by writes.
- Request inputs are ignored outside IDLE. Address and data changes mid-burst have no effect.
- `burst_resp` in IDLE or DONE is ignored.
- Requester contract: drop the request on the clock edge that ends `line_resp`. The adaptor samples a new request in IDLE, so it cannot re-issue a stale one.
- Beat counter width is `$clog2(BEATS)`. It never wraps within a transaction because DONE is entered on the final beat.

## Timing
- Reset values: `line_resp` 0, `line_rdata` 0, `burst_read` 0, `burst_write` 0, `burst_addr` 0, `burst_wdata` 0 (slot 0 of the cleared buffer); state IDLE, count 0.
- Reset mid-burst aborts the transaction. `burst_read`/`burst_write` are low in the cycle after the reset edge, and no `line_resp` is issued.
- All outputs decode directly from registered state and data, with no combinational path from inputs.
- Request seen in IDLE in cycle 0: `burst_read`/`burst_write` is high from cycle 1.
- If beats arrive in cycles k..k+BEATS-1, `line_resp` is high in cycle k+BEATS. `line_rdata` is valid in that same cycle.
- Back-to-back beats (one per cycle) and gapped beats (`burst_resp` low between beats) must both work.
- Minimum transaction: 1 + BEATS + 1 cycles from request to IDLE.

## Structure
- Shared package `cacheline_adaptor_pkg` holds:
  - the state enum;
  - the `BEATS` and counter-width constants derived from `s_line`/`s_burst`.
- One sub-module is natural: `burst_line_buffer`, an s_line-wide register with per-beat write enable indexed by `count`, a full-line parallel load, and a beat-select read mux. It is instantiated twice:
  - read assembly, which feeds `line_rdata`;
  - write staging, which feeds `burst_wdata`.

## Test plan
- Read, back-to-back beats:
  - Stimulus: `line_read` with `line_addr`=0x0000_1234; memory returns 64'hA0, A1, A2, A3 on consecutive cycles.
  - Required: `burst_addr`=0x0000_1220; `line_rdata`={A3,A2,A1,A0}; one-cycle `line_resp` one cycle after the last beat.
- Write, gapped beats:
  - Stimulus: `line_write`, `line_wdata`={D3,D2,D1,D0}; memory inserts 2 idle cycles between `burst_resp` pulses.
  - Required: `burst_wdata` shows D0..D3 in order, each held until its `burst_resp`; exactly one `line_resp`; `line_rdata` unchanged.
- Simultaneous request:
  - Stimulus: `line_read` and `line_write` high together.
  - Required: a write burst is issued (`burst_write`=1, `burst_read`=0).
- Request changes mid-transaction:
  - Stimulus: change `line_addr` and `line_wdata` after the first beat.
  - Required: `burst_addr` and the remaining beats keep the latched values.
- Reset mid-read:
  - Stimulus: assert `rst` after beat 1; release; issue a fresh read.
  - Required: no `line_resp` for the aborted read; the fresh read completes normally with counter restarted at 0.
- Stray response:
  - Stimulus: `burst_resp` pulsed in IDLE.
  - Required: no state change, no `line_resp`.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor shared types and sizing.
// Beat count and counter width derive from line and beat widths.
package cacheline_adaptor_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  function automatic int beats_of(int line_w, int burst_w);
    return line_w / burst_w;
  endfunction

  function automatic int cnt_w_of(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS = beats_of(S_LINE, S_BURST);
  localparam int CNT_W = cnt_w_of(BEATS);

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Line-request side and burst side of the adaptor.
// slave: the adaptor; master: requester plus memory.
interface cacheline_adaptor_if #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
);
  logic [31:0]        line_addr;
  logic               line_read;
  logic               line_write;
  logic [S_LINE-1:0]  line_wdata;
  logic [S_LINE-1:0]  line_rdata;
  logic               line_resp;
  logic [31:0]        burst_addr;
  logic               burst_read;
  logic               burst_write;
  logic [S_BURST-1:0] burst_wdata;
  logic [S_BURST-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  line_addr, line_read, line_write,
    input  line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_addr,
    output burst_read, burst_write, burst_wdata
  );

  modport master (
    output line_addr, line_read, line_write,
    output line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_addr,
    input  burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/burst_line_buffer.sv
// Line-wide register split into beats: parallel load,
// per-beat write at idx, beat-select read at sel.
module burst_line_buffer #(
  parameter int W  = 256,
  parameter int BW = 64,
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          we,
  input  logic [CW-1:0] idx,
  input  logic [BW-1:0] wdata,
  input  logic [CW-1:0] sel,
  output logic [W-1:0]  line,
  output logic [BW-1:0] beat
);

  logic [N-1:0][BW-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (load) begin
      buf_d = load_data;
    end else if (we) begin
      buf_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign line = buf_q;
  assign beat = buf_q[sel];

endmodule

// File: rtl/cacheline_adaptor.sv
// Whole-line read/write requests carried out as fixed-length
// beat bursts; read beats reassembled into one line.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST
) (
  input logic             clk,
  input logic             rst,
  cacheline_adaptor_if.slave bus
);

  localparam int Beats = beats_of(s_line, s_burst);
  localparam int CntW  = cnt_w_of(Beats);
  localparam logic [CntW-1:0] Last = CntW'(Beats - 1);
  localparam logic [31:0] OffMask =
    32'((64'd1 << s_offset) - 64'd1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [s_line-1:0]    rdata_q, rdata_d;
  logic [s_line-1:0]    asm_line;
  logic [Beats-1:0][s_burst-1:0] merged;
  logic                 rd_we, wr_load;
  logic [s_burst-1:0]   wr_beat;
  logic [s_burst-1:0]   rd_beat_unused;
  logic [s_line-1:0]    wr_line_unused;

  burst_line_buffer #(
    .W(s_line), .BW(s_burst), .N(Beats), .CW(CntW)
  ) u_rd_buf (
    .clk(clk), .rst(rst),
    .load(1'b0), .load_data('0),
    .we(rd_we), .idx(cnt_q), .wdata(bus.burst_rdata),
    .sel(cnt_q),
    .line(asm_line), .beat(rd_beat_unused)
  );

  burst_line_buffer #(
    .W(s_line), .BW(s_burst), .N(Beats), .CW(CntW)
  ) u_wr_buf (
    .clk(clk), .rst(rst),
    .load(wr_load), .load_data(bus.line_wdata),
    .we(1'b0), .idx(cnt_q), .wdata('0),
    .sel(cnt_q),
    .line(wr_line_unused), .beat(wr_beat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rd_we   = 1'b0;
    wr_load = 1'b0;
    // final line = assembled beats plus the one arriving now
    merged  = asm_line;
    merged[cnt_q] = bus.burst_rdata;
    unique case (state_q)
      IDLE: begin
        if (bus.line_write) begin
          state_d = WRITE;
          addr_d  = bus.line_addr & ~OffMask;
          cnt_d   = '0;
          wr_load = 1'b1;
        end else if (bus.line_read) begin
          state_d = READ;
          addr_d  = bus.line_addr & ~OffMask;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.burst_resp) begin
          rd_we = 1'b1;
          if (cnt_q == Last) begin
            state_d = DONE;
            rdata_d = merged;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (bus.burst_resp) begin
          if (cnt_q == Last) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.burst_read  = (state_q == READ);
  assign bus.burst_write = (state_q == WRITE);
  assign bus.line_resp   = (state_q == DONE);
  assign bus.burst_addr  = addr_q;
  assign bus.burst_wdata = wr_beat;
  assign bus.line_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboarded bench for cacheline_adaptor: reads, writes,
// gaps, priority, mid-burst changes, reset abort, stray beats.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
  } exp_t;

  exp_t         sb_q[$];
  logic [255:0] last_rd;
  int           vecs = 0;
  int           errs = 0;

  task automatic check_eq(string tag, logic [255:0] got,
                          logic [255:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // every line_resp retires one scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.line_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_resp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_rd) check_eq("rdata", bus.line_rdata, e.line);
        else check_eq("rdata_hold", bus.line_rdata, e.line);
      end
    end
  end

  task automatic wait_start(input bit wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((wr ? bus.burst_write : bus.burst_read) === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    check_eq("start_timeout", 0, 1);
  endtask

  task automatic do_xfer(input bit wr, input bit both,
                         input logic [31:0] addr,
                         input logic [255:0] line,
                         input int gap, input bit mutate);
    bit ok;
    logic [31:0] exp_addr;
    exp_addr = addr & ~32'h1F;
    if (wr) sb_q.push_back('{1'b0, last_rd});
    else begin
      sb_q.push_back('{1'b1, line});
      last_rd = line;
    end
    @(negedge clk);
    bus.line_addr  = addr;
    bus.line_wdata = wr ? line : '0;
    bus.line_write = wr;
    bus.line_read  = !wr || both;
    wait_start(wr, ok);
    if (!ok) begin
      void'(sb_q.pop_back());
      bus.line_read  = 1'b0;
      bus.line_write = 1'b0;
      return;
    end
    if (both) check_eq("prio_no_read", bus.burst_read, 0);
    check_eq("burst_addr", bus.burst_addr, exp_addr);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < ((k == 0) ? 0 : gap); g++) begin
        bus.burst_resp = 1'b0;
        @(negedge clk);
        if (wr) check_eq("wdata_hold", bus.burst_wdata,
                         line[k*64 +: 64]);
      end
      if (k == 1 && mutate) begin
        bus.line_addr  = 32'hDEAD_BEE0;
        bus.line_wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
      end
      if (wr) check_eq("wdata", bus.burst_wdata, line[k*64 +: 64]);
      if (k > 0) check_eq("addr_kept", bus.burst_addr, exp_addr);
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = wr ? 64'h0 : line[k*64 +: 64];
      @(negedge clk);
    end
    bus.burst_resp = 1'b0;
    check_eq("resp_latency", bus.line_resp, 1);
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    @(negedge clk);
    check_eq("resp_pulse", bus.line_resp, 0);
    check_eq("idle_rd", bus.burst_read, 0);
    check_eq("idle_wr", bus.burst_write, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [255:0] ln;
    rst = 1'b1;
    bus.line_addr   = '0;
    bus.line_read   = 1'b0;
    bus.line_write  = 1'b0;
    bus.line_wdata  = '0;
    bus.burst_rdata = '0;
    bus.burst_resp  = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_resp", bus.line_resp, 0);
    check_eq("rst_rdata", bus.line_rdata, 0);
    check_eq("rst_brd", bus.burst_read, 0);
    check_eq("rst_bwr", bus.burst_write, 0);
    check_eq("rst_baddr", bus.burst_addr, 0);
    check_eq("rst_bwdata", bus.burst_wdata, 0);
    rst = 1'b0;

    do_xfer(1'b0, 1'b0, 32'h0000_1234,
            {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0, 1'b0);
    do_xfer(1'b1, 1'b0, 32'h0000_2008,
            {64'hD3D3_0000_0000_00D3, 64'hD2D2_0000_0000_00D2,
             64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0},
            2, 1'b1);
    do_xfer(1'b1, 1'b1, 32'h0000_301F,
            {4{64'h5A5A_1234_8765_C3C3}}, 0, 1'b0);

    // stray beats in IDLE
    @(negedge clk);
    bus.burst_resp = 1'b1;
    @(negedge clk);
    bus.burst_resp = 1'b0;
    check_eq("stray_rd", bus.burst_read, 0);
    check_eq("stray_wr", bus.burst_write, 0);
    check_eq("stray_resp", bus.line_resp, 0);
    @(negedge clk);
    check_eq("stray_resp2", bus.line_resp, 0);

    ln = {$urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom};
    do_xfer(1'b0, 1'b0, 32'h8000_0047, ln, 1, 1'b0);

    // reset after two read beats
    @(negedge clk);
    bus.line_addr = 32'h0000_0040;
    bus.line_read = 1'b1;
    wait_start(1'b0, ok);
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = 64'hEE00 + 64'(k);
        @(negedge clk);
      end
    end
    bus.burst_resp = 1'b0;
    bus.line_read  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rd", bus.burst_read, 0);
    check_eq("abort_resp", bus.line_resp, 0);
    check_eq("abort_rdata", bus.line_rdata, 0);
    rst = 1'b0;
    last_rd = '0;
    @(negedge clk);
    check_eq("abort_resp2", bus.line_resp, 0);
    do_xfer(1'b0, 1'b0, 32'h0000_0044,
            {64'h33, 64'h22, 64'h11, 64'h00}, 1, 1'b0);

    for (int t = 0; t < 3; t++) begin
      ln = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      do_xfer(t[0], 1'b0, $urandom, ln, t, 1'b0);
    end

    repeat (2) @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
